// File: rtl/lcd_cmd_seq.sv
// Command initiator for LCD_CTRL: replays a preloaded command store under the
// busy handshake, then waits for done and reports completion or a fault.
module lcd_cmd_seq #(
    parameter int CMD_DEPTH = 64,
    parameter int AW        = 6,
    parameter int TIMEOUT   = 255,
    parameter int TW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [3:0]    prog_cmd,
    input  logic [AW:0]   cmd_len,
    input  logic          start,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic          seq_busy,
    output logic          seq_done,
    output logic          seq_err,
    output logic [1:0]    err_code,
    output logic [AW:0]   issued_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        ISSUE     = 3'd2,
        GAP       = 3'd3,
        WAIT_DONE = 3'd4,
        FIN       = 3'd5,
        ERR       = 3'd6
    } state_t;

    // The watchdog fires on the TIMEOUT-th consecutive stalled cycle.
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    state_t        state_r;
    logic [3:0]    mem_r [CMD_DEPTH];
    logic [AW:0]   ptr_r;
    logic [AW:0]   len_r;
    logic [TW-1:0] wdog_r;
    logic          err_set_s;
    logic [1:0]    err_cause_s;

    // Command store write port; loading is only allowed while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state_r == IDLE)) begin
            mem_r[prog_addr] <= prog_cmd;
        end
    end

    // Fault detection: premature done, busy stall and done timeout.
    always_comb begin
        err_set_s   = 1'b0;
        err_cause_s = 2'd0;
        case (state_r)
            ARM: begin
                if (done) begin
                    err_set_s   = 1'b1;
                    err_cause_s = 2'd3;
                end else if (busy && (wdog_r >= WDOG_LAST)) begin
                    err_set_s   = 1'b1;
                    err_cause_s = 2'd1;
                end else begin
                    err_set_s   = 1'b0;
                    err_cause_s = 2'd0;
                end
            end
            ISSUE, GAP: begin
                if (done) begin
                    err_set_s   = 1'b1;
                    err_cause_s = 2'd3;
                end else begin
                    err_set_s   = 1'b0;
                    err_cause_s = 2'd0;
                end
            end
            WAIT_DONE: begin
                if (!done && (wdog_r >= WDOG_LAST)) begin
                    err_set_s   = 1'b1;
                    err_cause_s = 2'd2;
                end else begin
                    err_set_s   = 1'b0;
                    err_cause_s = 2'd0;
                end
            end
            default: begin
                err_set_s   = 1'b0;
                err_cause_s = 2'd0;
            end
        endcase
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cmd        <= 4'd0;
            cmd_valid  <= 1'b0;
            seq_busy   <= 1'b0;
            seq_done   <= 1'b0;
            seq_err    <= 1'b0;
            err_code   <= 2'd0;
            issued_cnt <= '0;
            ptr_r      <= '0;
            len_r      <= '0;
            wdog_r     <= '0;
        end else if (err_set_s) begin
            state_r   <= ERR;
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            seq_busy  <= 1'b0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b1;
            err_code  <= err_cause_s;
            wdog_r    <= '0;
        end else begin
            seq_done <= 1'b0;
            case (state_r)
                IDLE, ERR: begin
                    if (start) begin
                        len_r      <= cmd_len;
                        ptr_r      <= '0;
                        issued_cnt <= '0;
                        wdog_r     <= '0;
                        seq_err    <= 1'b0;
                        err_code   <= 2'd0;
                        seq_busy   <= 1'b1;
                        state_r    <= (cmd_len != '0) ? ARM : FIN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ARM: begin
                    if (!busy) begin
                        cmd       <= mem_r[ptr_r[AW-1:0]];
                        cmd_valid <= 1'b1;
                        wdog_r    <= '0;
                        state_r   <= ISSUE;
                    end else begin
                        wdog_r <= wdog_r + TW'(1);
                    end
                end
                ISSUE: begin
                    cmd        <= 4'd0;
                    cmd_valid  <= 1'b0;
                    ptr_r      <= ptr_r + (AW+1)'(1);
                    issued_cnt <= issued_cnt + (AW+1)'(1);
                    wdog_r     <= '0;
                    state_r    <= GAP;
                end
                // Guard cycle: gives LCD_CTRL time to raise busy.
                GAP: begin
                    wdog_r  <= '0;
                    state_r <= (ptr_r < len_r) ? ARM : WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        wdog_r  <= '0;
                        state_r <= FIN;
                    end else begin
                        wdog_r <= wdog_r + TW'(1);
                    end
                end
                FIN: begin
                    seq_done <= 1'b1;
                    seq_busy <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    seq_busy <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: directed error/boundary scenarios plus
// randomized busy stalls checked against an edge-timeline reference model.
module tb_lcd_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       prog_we = 1'b0;
    logic [5:0] prog_addr = 6'd0;
    logic [3:0] prog_cmd = 4'd0;
    logic [6:0] cmd_len = 7'd0;
    logic       start = 1'b0;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       seq_busy;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] err_code;
    logic [6:0] issued_cnt;

    int total = 0;
    int bad = 0;

    logic [3:0] tb_mem [64];
    bit         busy_pat [2048];
    int         exp_idx [2048];

    lcd_cmd_seq dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_cmd(prog_cmd), .cmd_len(cmd_len), .start(start), .busy(busy),
        .done(done), .cmd(cmd), .cmd_valid(cmd_valid), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog(input int addr, input logic [3:0] val);
        prog_we   = 1'b1;
        prog_addr = 6'(addr);
        prog_cmd  = val;
        cyc();
        prog_we   = 1'b0;
        tb_mem[addr] = val;
    endtask

    task automatic do_start(input int len);
        cmd_len = 7'(len);
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    // Model: edge 0 samples start; each command is issued on the first
    // edge p (from 1, or 3 after the previous issue) with busy low; done is
    // looked at from 3 edges after the last issue; seq_done follows done by one edge.
    task automatic run_seq(input int len, input int prob, input int stall, input int ddly);
        int p;
        int d;
        for (int i = 0; i < 2048; i++) begin
            busy_pat[i] = (i >= 1 && i <= stall) ? 1'b1 : (32'($urandom_range(99)) < 32'(prob));
            exp_idx[i]  = -1;
        end
        p = 1;
        for (int k = 0; k < len; k++) begin
            while (busy_pat[p]) p++;
            exp_idx[p] = k;
            p += 3;
        end
        d = p + ddly;
        busy = busy_pat[0];
        done = 1'b0;
        do_start(len);
        chk("start_seq_busy", seq_busy, 1);
        chk("start_err_clr", seq_err, 0);
        chk("start_code_clr", err_code, 0);
        for (int r = 1; r <= d + 2; r++) begin
            busy = busy_pat[r];
            done = (r == d);
            cyc();
            chk("cmd_valid", cmd_valid, exp_idx[r] >= 0);
            if (exp_idx[r] >= 0) chk("cmd_value", cmd, tb_mem[exp_idx[r]]);
            chk("seq_done", seq_done, r == d + 1);
            chk("seq_busy", seq_busy, r <= d);
        end
        busy = 1'b0;
        done = 1'b0;
        chk("issued_cnt", issued_cnt, len);
        chk("no_err", seq_err, 0);
    endtask

    initial begin
        logic saw;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_cmd", cmd, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_issued", issued_cnt, 0);
        reset = 1'b0;
        cyc();

        // Basic 4-command sequence with busy held low.
        prog(0, 4'd1); prog(1, 4'd3); prog(2, 4'd5); prog(3, 4'd0);
        run_seq(4, 0, 0, 2);

        // Randomized contents, lengths and busy stalls.
        for (int i = 0; i < 64; i++) prog(i, 4'($urandom_range(15)));
        repeat (6) begin
            run_seq(int'($urandom_range(12, 1)), 30, 0, int'($urandom_range(5)));
        end

        // Full-depth sequence.
        run_seq(64, 20, 0, 3);

        // Long busy after reset (image load) before the first command.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        prog(0, 4'd0);
        run_seq(1, 0, 70, 1);

        // Zero-length sequence.
        do_start(0);
        chk("len0_done_early", seq_done, 0);
        cyc();
        chk("len0_done", seq_done, 1);
        chk("len0_valid", cmd_valid, 0);
        cyc();
        chk("len0_done_clr", seq_done, 0);
        chk("len0_issued", issued_cnt, 0);

        // Busy stuck high: timeout on the 255th ARM cycle.
        busy = 1'b1;
        saw  = 1'b0;
        do_start(1);
        for (int i = 1; i <= 255; i++) begin
            cyc();
            if (cmd_valid) saw = 1'b1;
            if (i == 254) chk("busy_to_early", seq_err, 0);
        end
        chk("busy_to_err", seq_err, 1);
        chk("busy_to_code", err_code, 1);
        chk("busy_to_novalid", saw, 0);
        chk("busy_to_seq_busy", seq_busy, 0);
        busy = 1'b0;
        // A write while in ERR must not reach the store.
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_cmd  = ~tb_mem[0];
        cyc();
        prog_we   = 1'b0;
        run_seq(1, 0, 0, 1);

        // done never rises after the last command.
        do_start(1);
        repeat (257) cyc();
        chk("done_to_early", seq_err, 0);
        cyc();
        chk("done_to_err", seq_err, 1);
        chk("done_to_code", err_code, 2);
        chk("done_to_issued", issued_cnt, 1);

        // Premature done during the GAP after command 2 of 4.
        do_start(4);
        repeat (5) cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("prem_err", seq_err, 1);
        chk("prem_code", err_code, 3);
        chk("prem_issued", issued_cnt, 2);
        chk("prem_valid", cmd_valid, 0);

        // Asynchronous reset while a command is on the bus, then replay.
        do_start(2);
        cyc();
        chk("issue_valid", cmd_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", cmd_valid, 0);
        chk("async_rst_busy", seq_busy, 0);
        chk("async_rst_err", seq_err, 0);
        cyc();
        reset = 1'b0;
        cyc();
        run_seq(4, 25, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Synthesizable command initiator that drives the LCD_CTRL cmd/cmd_valid/busy/done interface from an internal programmable command store.
- Replaces the bench-side command feeder in on-chip self-test configurations.
- Software or a loader preloads up to CMD_DEPTH 4-bit commands, then pulses start.
- The block issues each command under the busy handshake, waits for done after the last command, and reports completion or a protocol/timeout error.

Parameters:
- CMD_DEPTH, 64: command store entries.
- AW, 6: address width of the store and of cmd_len; CMD_DEPTH = 2**AW.
- TIMEOUT, 255: maximum consecutive cycles of busy=1 (in ARM) or done=0 (in WAIT_DONE) before an error.
- TW, 8: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  command store write strobe; honoured only in IDLE.
- prog_addr  in  AW  command store write address.
- prog_cmd  in  4  command opcode to store.
- cmd_len  in  AW+1  number of commands to issue (0..CMD_DEPTH); sampled on start.
- start  in  1  begin sequence; honoured only in IDLE or ERR.
- busy  in  1  LCD_CTRL busy.
- done  in  1  LCD_CTRL done.
- cmd  out  4  command to LCD_CTRL; registered.
- cmd_valid  out  1  command strobe; registered; 1-cycle pulse.
- seq_busy  out  1  high in every state except IDLE and ERR.
- seq_done  out  1  1-cycle pulse when a sequence completes.
- seq_err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 busy timeout, 2 done timeout, 3 premature done.
- issued_cnt  out  AW+1  number of commands issued in the current/last sequence.

Behaviour:
- Reset values: cmd=0, cmd_valid=0, seq_busy=0, seq_done=0, seq_err=0, err_code=0, issued_cnt=0, ptr=0, wdog=0, state=IDLE. The store contents are not reset.
- States: IDLE, ARM, ISSUE, GAP, WAIT_DONE, FIN, ERR.
- IDLE:
  - prog_we writes prog_cmd to mem[prog_addr] at the clock edge.
  - On start: latch len=cmd_len, clear ptr and issued_cnt, then go to ARM if len>0, else to FIN.
  - A prog_we in the same cycle as start is committed and is visible to the sequence.
- ARM:
  - If busy=0, load cmd<=mem[ptr] and cmd_valid<=1, then go to ISSUE. cmd_valid is therefore high during the whole ISSUE cycle.
  - If busy=1, increment wdog. When wdog reaches TIMEOUT, go to ERR with err_code=1.
  - wdog clears on every state entry.
- ISSUE: cmd_valid<=0, cmd<=0, ptr++, issued_cnt++, go to GAP.
- GAP:
  - One mandatory guard cycle so LCD_CTRL can raise busy in response to the command; busy is ignored here.
  - Go to ARM if ptr<len, else to WAIT_DONE.
- WAIT_DONE:
  - done=1 → FIN.
  - Otherwise increment wdog; at TIMEOUT go to ERR with err_code=2.
- FIN: seq_done=1 for exactly one cycle, then IDLE.
- Premature done: done=1 while in ARM, ISSUE or GAP → ERR with err_code=3. cmd_valid is forced to 0 on the following edge.
- ERR:
  - seq_err=1 and outputs are idle; holds until start or reset.
  - start in ERR clears seq_err and err_code, then behaves as start in IDLE.
  - prog_we is ignored in ERR.
- Ignored inputs: start and prog_we outside IDLE/ERR (prog_we outside IDLE) are ignored with no side effects.
- Issue rate: at most one command per 3 cycles (ARM, ISSUE, GAP). Two cmd_valid pulses are never adjacent.
- Asynchronous reset mid-sequence clears cmd_valid immediately and returns to IDLE. The store is retained.
- Arithmetic: ptr and issued_cnt are AW+1 bits, so len=CMD_DEPTH completes without wrap. wdog saturates at TIMEOUT.

Test Plan:
- Load 4 cmds {1,3,5,0}, len=4, busy held 0 → cmd_valid pulses 3 cycles apart carrying 1,3,5,0. Then done=1 gives seq_done one cycle later; issued_cnt=4.
- Post-reset busy=1 for 70 cycles (image load), len=1, cmd 0 → no cmd_valid until the first cycle busy=0 is sampled; the first cmd_valid appears 1 cycle after that.
- busy stuck 1, TIMEOUT=255 → after 255 ARM cycles: seq_err=1, err_code=1, no cmd_valid. A subsequent start clears the error.
- Last cmd issued, done never rises → err_code=2 after TIMEOUT cycles. Separately, done pulse during GAP of cmd 2 of 4 → err_code=3, issued_cnt=2.
- len=0 start → seq_done pulses 2 cycles after start, no cmd_valid. len=64 with all entries programmed → 64 issues, issued_cnt=64.
- Reset asserted during ISSUE → cmd_valid=0 without waiting for a clock edge. A restart after reset replays the retained store from entry 0.
